serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing `a - b - bin` over `WIDTH` clock cycles, LSB first. It uses one `full_subtractor` cell and a registered borrow in place of a `WIDTH`-bit ripple chain. It sits in the datapath as the sequential wrapper around that gate-level cell: parallel operands in, parallel difference and borrow out, with a start/done handshake.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encodings and default width for the serial subtractor
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done operand bus of the serial subtractor (ovf with SERIAL_SUB_OVF_EN)
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell: diff = a - b - bin
module full_subtractor (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock (ovf with SERIAL_SUB_OVF_EN)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             cell_diff;
    logic             cell_bout;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_q;
`endif

    full_subtractor u_cell (
        .diff (cell_diff),
        .bout (cell_bout),
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow)
    );

    assign last = (state == RUN) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (last)      next_state = DONE;
            DONE:                   next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Operands are only loaded in IDLE, so a start seen while busy cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            busy_q <= (next_state != IDLE);
            done_q <= last;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        borrow <= bus.bin;
                        cnt    <= '0;
                        res_sr <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {cell_diff, res_sr[WIDTH-1:1]};
                    borrow <= cell_bout;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        diff_q <= {cell_diff, res_sr[WIDTH-1:1]};
                        bout_q <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q  <= (a_msb ^ b_msb) & (a_msb ^ cell_diff);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (ovf checks with SERIAL_SUB_OVF_EN)
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_count = 0;
    exp_t exp_q[$];
    vec_t tbl[14];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_if #(.WIDTH(W)) dut_if ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        vec_t     v;
        logic [W:0] r;
        r    = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        v.a  = a;
        v.b  = b;
        v.bin = bin;
        v.d  = r[W-1:0];
        v.bo = r[W];
        v.ov = (a[W-1] ^ b[W-1]) & (a[W-1] ^ r[W-1]);
        return v;
    endfunction

    // Scoreboard: every done pops the oldest expectation.
    always @(negedge clk) begin
        if (dut_if.done) begin
            exp_t e;
            done_count++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("diff", 32'(dut_if.diff), 32'(e.d));
                chk("bout", 32'(dut_if.bout), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", 32'(dut_if.ovf), 32'(e.ov));
`endif
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int limit, output int lat);
        int n;
        n = 0;
        while (!dut_if.done && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!dut_if.done) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
        lat = n;
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        dut_if.a     = v.a;
        dut_if.b     = v.b;
        dut_if.bin   = v.bin;
        dut_if.start = 1'b1;
        exp_q.push_back('{d: v.d, bo: v.bo, ov: v.ov});
        tick(1);
        dut_if.start = 1'b0;
        chk("busy_after_accept", 32'(dut_if.busy), 32'd1);
        wait_done(3 * W, lat);
        chk("latency", 32'(lat), 32'(W));
        tick(1);
        chk("done_single_cycle", 32'(dut_if.done), 32'd0);
        chk("busy_falls", 32'(dut_if.busy), 32'd0);
    endtask

    initial begin
        int   lat;
        int   c1;
        int   c2;
        int   dc0;
        vec_t v;

        tbl[0] = '{a: 8'h35, b: 8'h12, bin: 1'b0, d: 8'h23, bo: 1'b0, ov: 1'b0};
        tbl[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1, ov: 1'b0};
        tbl[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1};
        tbl[3] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, bo: 1'b0, ov: 1'b0};
        tbl[4] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, bo: 1'b1, ov: 1'b1};
        tbl[5] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0};
        tbl[6] = '{a: 8'hFF, b: 8'hFF, bin: 1'b0, d: 8'h00, bo: 1'b0, ov: 1'b0};
        tbl[7] = '{a: 8'h80, b: 8'h7F, bin: 1'b1, d: 8'h00, bo: 1'b0, ov: 1'b1};
        for (int i = 8; i < 14; i++)
            tbl[i] = mk(W'($urandom), W'($urandom), 1'($urandom));

        dut_if.start = 1'b0;
        dut_if.a     = '0;
        dut_if.b     = '0;
        dut_if.bin   = 1'b0;

        tick(2);
        chk("rst_busy", 32'(dut_if.busy), 32'd0);
        chk("rst_done", 32'(dut_if.done), 32'd0);
        chk("rst_diff", 32'(dut_if.diff), 32'd0);
        chk("rst_bout", 32'(dut_if.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(dut_if.ovf), 32'd0);
`endif
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 14; i++) run_op(tbl[i]);

        // Result holds while inputs wander with no start.
        dut_if.a = 8'hAA;
        dut_if.b = 8'h55;
        tick(4);
        chk("hold_diff", 32'(dut_if.diff), 32'(tbl[13].d));
        chk("hold_bout", 32'(dut_if.bout), 32'(tbl[13].bo));

        // Start pulsed during RUN is ignored.
        dc0 = done_count;
        dut_if.a     = 8'h35;
        dut_if.b     = 8'h12;
        dut_if.bin   = 1'b0;
        dut_if.start = 1'b1;
        exp_q.push_back('{d: 8'h23, bo: 1'b0, ov: 1'b0});
        tick(1);
        dut_if.start = 1'b0;
        tick(3);
        dut_if.a     = 8'hFF;
        dut_if.b     = 8'h01;
        dut_if.bin   = 1'b1;
        dut_if.start = 1'b1;
        tick(1);
        dut_if.start = 1'b0;
        wait_done(3 * W, lat);
        tick(W + 4);
        chk("ignored_start_done_count", 32'(done_count - dc0), 32'd1);
        chk("ignored_start_diff", 32'(dut_if.diff), 32'h23);
        chk("ignored_start_busy", 32'(dut_if.busy), 32'd0);

        // Start held high: back-to-back operations.
        dut_if.a     = 8'h35;
        dut_if.b     = 8'h12;
        dut_if.bin   = 1'b0;
        dut_if.start = 1'b1;
        exp_q.push_back('{d: 8'h23, bo: 1'b0, ov: 1'b0});
        tick(1);
        v = tbl[2];
        dut_if.a   = v.a;
        dut_if.b   = v.b;
        dut_if.bin = v.bin;
        exp_q.push_back('{d: v.d, bo: v.bo, ov: v.ov});
        wait_done(3 * W, lat);
        c1 = cyc;
        tick(1);
        wait_done(3 * W, lat);
        c2 = cyc;
        dut_if.start = 1'b0;
        chk("b2b_spacing", 32'(c2 - c1), 32'(W + 2));
        tick(3);
        chk("b2b_idle", 32'(dut_if.busy), 32'd0);

        // Reset mid-operation discards the partial result.
        dc0 = done_count;
        dut_if.a     = 8'h80;
        dut_if.b     = 8'h01;
        dut_if.start = 1'b1;
        tick(1);
        dut_if.start = 1'b0;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(dut_if.busy), 32'd0);
        chk("midrst_done", 32'(dut_if.done), 32'd0);
        chk("midrst_diff", 32'(dut_if.diff), 32'd0);
        chk("midrst_bout", 32'(dut_if.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("midrst_ovf", 32'(dut_if.ovf), 32'd0);
`endif
        tick(2);
        rst_n = 1'b1;
        tick(W + 4);
        chk("midrst_no_done", 32'(done_count - dc0), 32'd0);
        run_op(tbl[0]);

        tick(2);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
